// File: rtl/surf_dout_pkg.sv
// Shared definitions for the SURF dout event transmitter and the TURFIO-side splicer:
// frame sizes, transmitter states, header start marker and test-pattern sample packing.
package surf_dout_pkg;

   localparam int NUM_BYTES = 12292;
   localparam int HDR_BYTES = 4;

   // Bit 7 of header byte 0 is the only marker the splicer hunts for.
   localparam logic [7:0] HDR_MARK = 8'h80;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DATA = 2'd2
   } tx_state_e;

   // Two 12-bit samples into three bytes; byte 0 of the group sits in [7:0].
   function automatic logic [23:0] pack_pair(input logic [11:0] a, input logic [11:0] b);
      return {b[11:4], b[3:0], a[11:8], a[7:0]};
   endfunction

endpackage

// File: rtl/surf_trig_fifo.sv
// Trigger-time FIFO. Incoming pushes pass through one register stage, so a trigger
// is visible as non-empty two cycles after its strobe. A push into a full FIFO is dropped.
module surf_trig_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             ovf_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic             wr_q, wr_d;
   logic [WIDTH-1:0] wr_data_q, wr_data_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_wr, do_rd;

   assign full_o    = (count_q == CW'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign rd_data_o = mem_q[rd_ptr_q];

   always_comb begin
      wr_d      = wr_i;
      wr_data_d = wr_data_i;
      do_rd     = rd_i && !empty_o;
      // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
      do_wr     = wr_q && (!full_o || do_rd);
      ovf_o     = wr_q && !do_wr;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (do_wr) wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
      if (do_wr && !do_rd) count_d = count_q + CW'(1);
      else if (do_rd && !do_wr) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q      <= 1'b0;
         wr_data_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         wr_q      <= wr_d;
         wr_data_q <= wr_data_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data_q;
   end

endmodule

// File: rtl/surf_dout_tx.sv
// SURF dout event transmitter: 4-byte header plus sample bytes per trigger, one byte per byte_ce_i.
// Define SURF_DOUT_TX_TESTPAT_EN to replace readout samples with an internal 12-bit ramp.
module surf_dout_tx #(
   parameter int NUM_BYTES       = surf_dout_pkg::NUM_BYTES,
   parameter int HDR_BYTES       = surf_dout_pkg::HDR_BYTES,
   parameter int TRIG_FIFO_DEPTH = 16
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        trig_i,
   input  logic [14:0] trig_time_i,
   input  logic        byte_ce_i,
   input  logic [7:0]  s_data_tdata,
   input  logic        s_data_tvalid,
   output logic        s_data_tready,
   output logic [7:0]  m_dout_tdata,
   output logic        m_dout_tvalid,
   output logic [1:0]  err_o
);

   localparam logic [13:0] LAST_HDR  = 14'(HDR_BYTES - 1);
   localparam logic [13:0] LAST_BYTE = 14'(NUM_BYTES - 1);

   surf_dout_pkg::tx_state_e state_q, state_d;
   logic [13:0] byte_cnt_q, byte_cnt_d;
   logic [15:0] evcnt_q, evcnt_d, hdr_ev_q, hdr_ev_d;
   logic [7:0]  time_lo_q, time_lo_d;
   logic [7:0]  dout_q, dout_d;
   logic        dvalid_q, dvalid_d;
   logic [1:0]  err_q, err_d;

   logic        fifo_pop, fifo_empty, fifo_ovf, unused_fifo_full;
   logic [14:0] fifo_time;
   logic [7:0]  data_byte;
   logic        data_ok;

   surf_trig_fifo #(
      .DEPTH(TRIG_FIFO_DEPTH),
      .WIDTH(15)
   ) u_trig_fifo (
      .clk      (aclk),
      .rst_n    (aresetn),
      .wr_i     (trig_i),
      .wr_data_i(trig_time_i),
      .rd_i     (fifo_pop),
      .rd_data_o(fifo_time),
      .full_o   (unused_fifo_full),
      .empty_o  (fifo_empty),
      .ovf_o    (fifo_ovf)
   );

`ifdef SURF_DOUT_TX_TESTPAT_EN
   logic [11:0] samp_q, samp_d;
   logic [1:0]  ph_q, ph_d;
   logic [23:0] pair;
   logic        unused_sdata;

   assign unused_sdata  = ^{s_data_tdata, s_data_tvalid};
   assign pair          = surf_dout_pkg::pack_pair(samp_q, samp_q + 12'd1);
   assign data_ok       = 1'b1;
   assign s_data_tready = 1'b0;

   always_comb begin
      data_byte = pair[7:0];
      case (ph_q)
         2'd1:    data_byte = pair[15:8];
         2'd2:    data_byte = pair[23:16];
         default: data_byte = pair[7:0];
      endcase
      samp_d = samp_q;
      ph_d   = ph_q;
      // Ramp restarts at zero for every event; IDLE always precedes one.
      if (state_q == surf_dout_pkg::IDLE) begin
         samp_d = '0;
         ph_d   = '0;
      end else if (state_q == surf_dout_pkg::DATA && byte_ce_i) begin
         if (ph_q == 2'd2) begin
            ph_d   = '0;
            samp_d = samp_q + 12'd2;
         end else begin
            ph_d = ph_q + 2'd1;
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         samp_q <= '0;
         ph_q   <= '0;
      end else begin
         samp_q <= samp_d;
         ph_q   <= ph_d;
      end
   end
`else
   assign data_byte     = s_data_tdata;
   assign data_ok       = s_data_tvalid;
   assign s_data_tready = (state_q == surf_dout_pkg::DATA) && byte_ce_i;
`endif

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      evcnt_d    = evcnt_q;
      hdr_ev_d   = hdr_ev_q;
      time_lo_d  = time_lo_q;
      dout_d     = 8'h00;
      dvalid_d   = 1'b0;
      err_d      = {err_q[1], err_q[0] | fifo_ovf};
      fifo_pop   = 1'b0;
      case (state_q)
         surf_dout_pkg::IDLE: begin
            if (byte_ce_i && !fifo_empty) begin
               fifo_pop   = 1'b1;
               dvalid_d   = 1'b1;
               dout_d     = surf_dout_pkg::HDR_MARK | {1'b0, fifo_time[14:8]};
               time_lo_d  = fifo_time[7:0];
               // The header carries the count before this event's increment.
               hdr_ev_d   = evcnt_q;
               evcnt_d    = evcnt_q + 16'd1;
               byte_cnt_d = 14'd1;
               state_d    = surf_dout_pkg::HDR;
            end
         end
         surf_dout_pkg::HDR: begin
            if (byte_ce_i) begin
               dvalid_d = 1'b1;
               case (byte_cnt_q[1:0])
                  2'd1:    dout_d = time_lo_q;
                  2'd2:    dout_d = hdr_ev_q[15:8];
                  default: dout_d = hdr_ev_q[7:0];
               endcase
               byte_cnt_d = byte_cnt_q + 14'd1;
               if (byte_cnt_q == LAST_HDR) state_d = surf_dout_pkg::DATA;
            end
         end
         surf_dout_pkg::DATA: begin
            if (byte_ce_i) begin
               dvalid_d = 1'b1;
               // Missing samples become zero so the frame length never changes.
               dout_d   = data_ok ? data_byte : 8'h00;
               if (!data_ok) err_d[1] = 1'b1;
               byte_cnt_d = byte_cnt_q + 14'd1;
               if (byte_cnt_q == LAST_BYTE) state_d = surf_dout_pkg::IDLE;
            end
         end
         default: state_d = surf_dout_pkg::IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= surf_dout_pkg::IDLE;
         byte_cnt_q <= '0;
         evcnt_q    <= '0;
         hdr_ev_q   <= '0;
         time_lo_q  <= '0;
         dout_q     <= '0;
         dvalid_q   <= 1'b0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         evcnt_q    <= evcnt_d;
         hdr_ev_q   <= hdr_ev_d;
         time_lo_q  <= time_lo_d;
         dout_q     <= dout_d;
         dvalid_q   <= dvalid_d;
         err_q      <= err_d;
      end
   end

   assign m_dout_tdata  = dout_q;
   assign m_dout_tvalid = dvalid_q;
   assign err_o         = err_q;

endmodule

// File: doc/surf_dout_tx.md
# surf_dout_tx

SURF-side event byte transmitter: serializes each triggered event onto the 8-bit SURF dout stream. The stream has no backpressure. Each event is 4 header bytes followed by 8 × 1536 sample bytes, 12,292 bytes in total. Header byte 0 always has bit 7 set, so the TURFIO-side splicer can find the start of an event by hunting for that bit. The block sits between the SURF sample-readout AXI4-stream and the dout serializer, which paces it with a byte clock-enable.

## Interface
Parameters:
- NUM_BYTES, 12292: bytes per event, header included.
- HDR_BYTES, 4: header length in bytes.
- TRIG_FIFO_DEPTH, 16: number of pending triggers the block can hold.

Ports:
- aclk  in  1  clock for all logic.
- aresetn  in  1  reset; asynchronous assertion, active-low.
- trig_i  in  1  one-cycle trigger strobe.
- trig_time_i  in  15  trigger time, captured when trig_i is high.
- byte_ce_i  in  1  byte slot; exactly one byte is emitted per assertion while an event is in progress.
- s_data_tdata  in  8  packed sample bytes from readout.
- s_data_tvalid  in  1  sample byte available.
- s_data_tready  out  1  sample byte consumed this cycle.
- m_dout_tdata  out  8  dout byte.
- m_dout_tvalid  out  1  byte strobe (fake stream, no tready).
- err_o  out  2  sticky errors: [0] trigger FIFO overflow, [1] data underrun.

## Operation
- Trigger intake: on trig_i, push {trig_time_i} into the trigger FIFO. If the FIFO is full, drop the trigger and set err_o[0].
- Event counter: 16-bit evcnt. Reset value 0. Increments when header byte 0 is emitted and wraps 0xFFFF→0.
- Header bytes, in order:
  - byte 0: {1'b1, time[14:8]}
  - byte 1: time[7:0]
  - byte 2: evcnt[15:8]
  - byte 3: evcnt[7:0]
- FSM states: IDLE, HDR, DATA.
  - IDLE: if byte_ce_i and the FIFO is non-empty, emit byte 0, pop the FIFO, set byte_cnt=1, go to HDR. Otherwise emit nothing (m_dout_tvalid=0).
  - HDR: on each byte_ce_i, emit the header byte selected by byte_cnt and increment byte_cnt. After byte 3, go to DATA.
  - DATA: on each byte_ce_i, emit s_data_tdata and assert s_data_tready for that cycle.
    - If s_data_tvalid=0, emit 0x00 and set err_o[1]. Framing is preserved and byte_cnt still advances.
    - After byte NUM_BYTES-1, go to IDLE.
- byte_cnt is 14 bits and is only compared against NUM_BYTES-1; it never wraps.
- s_data_tready = (state==DATA) && byte_ce_i. It is never asserted in IDLE or HDR.
- Back-to-back events: if a trigger is pending, byte 0 of the next event goes out on the first byte_ce_i after the last data byte. No gap is inserted.
- Simultaneous FIFO push and pop are both honoured; occupancy is unchanged.
- Asynchronous reset, including mid-event:
  - FSM → IDLE, FIFO emptied, evcnt=0, err_o=0, m_dout_tvalid=0, m_dout_tdata=0, s_data_tready=0.
  - A truncated event is not completed after reset.

## Timing
- Output is registered: byte_ce_i in cycle N gives m_dout_tvalid=1 and valid data in cycle N+1, for exactly one cycle.
- Trigger FIFO latency: trig_i in cycle N makes the FIFO non-empty in cycle N+2. The earliest header byte 0 is emitted on a byte_ce_i in cycle ≥N+2.
- s_data_tready is combinational from state and byte_ce_i, and coincides with the byte_ce_i cycle.
- err_o bits are registered and update one cycle after the causing event.

## Configuration
- SURF_DOUT_TX_TESTPAT_EN defined:
  - DATA bytes come from an internal ramp instead of s_data. s_data_tready stays 0 and underrun cannot occur.
  - The ramp is 12-bit samples starting at 0x000 each event and incrementing by 1 per sample, wrapping at 0xFFF.
  - Samples are packed in pairs (a,b) as a[7:0], {b[3:0],a[11:8]}, b[11:4].
- SURF_DOUT_TX_TESTPAT_EN not defined: no ramp logic is compiled in and behaviour is as in Operation.

## Structure
- Shared package surf_dout_pkg holds:
  - NUM_BYTES and HDR_BYTES;
  - the state enum {IDLE,HDR,DATA};
  - the header bit-7 marker constant;
  - the sample-pair packing function. The TURFIO-side splicer uses the same package.
- One sub-module: surf_trig_fifo, a 15-bit wide, TRIG_FIFO_DEPTH-deep synchronous FIFO with full/empty flags and an overflow flag.

## Test plan
- Single event: trig_i with trig_time_i=0x1234, byte_ce_i every 4th cycle, s_data ramp byte k=k[7:0] → bytes 0x92,0x34,0x00,0x00, then 12,288 data bytes matching the ramp; s_data_tready count = 12,288; err_o=0.
- Back-to-back: two triggers (times 0x0001, 0x7FFF) before the first header, byte_ce_i every cycle → second header 0x80,0x01… is followed by 0xFF,0xFF,0x00,0x01, starting on the cycle after byte 12,291 of the first event.
- Overflow: 17 triggers with byte_ce_i=0 → err_o[0]=1; after enabling byte_ce_i, exactly 16 events are emitted.
- Underrun: s_data_tvalid=0 for data byte 100 → that byte is 0x00; err_o[1]=1; event length is still 12,292.
- Reset mid-event: aresetn low at byte 5000 → m_dout_tvalid=0 immediately; the next trigger produces evcnt bytes 0x00,0x00.
- With SURF_DOUT_TX_TESTPAT_EN: data bytes 4..9 = 0x00,0x10,0x00,0x02,0x30,0x00.
